// File: rtl/rgmii_dly_pkg.sv
// Shared types and default constants for the RGMII receive-path delay controller.
package rgmii_dly_pkg;
  localparam int DEF_LANES   = 5;
  localparam int DEF_TAP_W   = 5;
  localparam int DEF_MAX_TAP = 31;

  typedef logic [DEF_TAP_W-1:0] tap_t;

  typedef enum logic [2:0] {
    WAIT_RDY,
    LOAD,
    SETTLE,
    IDLE,
    STEP,
    ERROR
  } dly_state_e;
endpackage

// File: rtl/rgmii_idelay_lane.sv
// One delay lane: shadow tap register with load-time clamp and saturating +/-1 step.
module rgmii_idelay_lane
  import rgmii_dly_pkg::*;
#(
  parameter int TAP_W   = DEF_TAP_W,
  parameter int MAX_TAP = DEF_MAX_TAP
) (
  input  logic             clk_int,
  input  logic             rst_int_n,
  input  logic             load,
  input  logic [TAP_W-1:0] cfg_tap,
  input  logic             step,
  input  logic             inc,
  output logic [TAP_W-1:0] tap,
  output logic             at_lim
);
  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(MAX_TAP);

  // A step that would leave [0, MAX_TAP] is refused so the element never wraps.
  always_comb at_lim = inc ? (tap == TAP_MAX) : (tap == '0);

  always_ff @(posedge clk_int) begin
    if (!rst_int_n)           tap <= '0;
    else if (load)            tap <= (cfg_tap > TAP_MAX) ? TAP_MAX : cfg_tap;
    else if (step && !at_lim) tap <= inc ? tap + 1'b1 : tap - 1'b1;
  end
endmodule

// File: rtl/rgmii_idelay_ctrl.sv
// Run-time controller for RGMII RX input delays: waits for the delay reference,
// loads per-lane taps, then services single-step requests with settle gaps.
module rgmii_idelay_ctrl
  import rgmii_dly_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int TAP_W       = DEF_TAP_W,
  parameter int MAX_TAP     = DEF_MAX_TAP,
  parameter int SETTLE_CYC  = 4,
  parameter int RDY_TIMEOUT = 1024
) (
  input  logic                     clk_int,
  input  logic                     rst_int_n,
  input  logic                     dlyctrl_rdy_i,
  input  logic [LANES*TAP_W-1:0]   cfg_tap_i,
  input  logic                     cfg_load_i,
  input  logic                     step_valid_i,
  input  logic [$clog2(LANES)-1:0] step_lane_i,
  input  logic                     step_inc_i,
  output logic                     step_ready_o,
  output logic [LANES-1:0]         dly_ld_o,
  output logic [LANES-1:0]         dly_ce_o,
  output logic                     dly_inc_o,
  output logic [LANES*TAP_W-1:0]   dly_cntvaluein_o,
  output logic [LANES*TAP_W-1:0]   tap_o,
  output logic                     busy_o,
  output logic                     ready_o,
  output logic                     err_o
);
  localparam int LW    = $clog2(LANES);
  localparam int TMR_W = $clog2(RDY_TIMEOUT + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  dly_state_e                    state;
  logic [TMR_W-1:0]              rdy_tmr;
  logic [SET_W-1:0]              settle_cnt;
  logic [LANES-1:0][TAP_W-1:0]   cfg_arr, tap_arr;
  logic [LANES-1:0]              sel, at_lim;
  logic [2**LW-1:0]              lim_ext;
  logic                          go_load, accept, clip;

  assign cfg_arr          = cfg_tap_i;
  assign tap_o            = tap_arr;
  // The element only samples CNTVALUEIN on LD, so the shadow doubles as load value.
  assign dly_cntvaluein_o = tap_arr;

  assign busy_o       = (state != IDLE);
  assign step_ready_o = (state == IDLE) && dlyctrl_rdy_i && !cfg_load_i;
  assign accept       = step_valid_i && step_ready_o;
  assign go_load      = dlyctrl_rdy_i &&
                        ((state == WAIT_RDY) || ((state == IDLE) && cfg_load_i));

  // Lane indices past LANES read as "at limit" so they are refused like a clip.
  always_comb begin
    lim_ext            = '1;
    lim_ext[LANES-1:0] = at_lim;
  end
  assign clip = lim_ext[step_lane_i];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sel[i] = (step_lane_i == LW'(i));
    rgmii_idelay_lane #(.TAP_W(TAP_W), .MAX_TAP(MAX_TAP)) u_lane (
      .clk_int  (clk_int),
      .rst_int_n(rst_int_n),
      .load     (go_load),
      .cfg_tap  (cfg_arr[i]),
      .step     (accept && sel[i]),
      .inc      (step_inc_i),
      .tap      (tap_arr[i]),
      .at_lim   (at_lim[i])
    );
  end

  always_ff @(posedge clk_int) begin
    if (!rst_int_n) begin
      state      <= WAIT_RDY;
      rdy_tmr    <= '0;
      settle_cnt <= '0;
      dly_ld_o   <= '0;
      dly_ce_o   <= '0;
      dly_inc_o  <= 1'b0;
      ready_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      dly_ld_o <= '0;
      dly_ce_o <= '0;
      unique case (state)
        WAIT_RDY: begin
          if (go_load) begin
            state    <= LOAD;
            dly_ld_o <= '1;
            rdy_tmr  <= '0;
          end else if (rdy_tmr == TMR_W'(RDY_TIMEOUT - 1)) begin
            state <= ERROR;
            err_o <= 1'b1;
          end else begin
            rdy_tmr <= rdy_tmr + 1'b1;
          end
        end
        LOAD, STEP: begin
          state      <= SETTLE;
          settle_cnt <= '0;
        end
        SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
            state   <= IDLE;
            ready_o <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (!dlyctrl_rdy_i) begin
            state   <= WAIT_RDY;
            ready_o <= 1'b0;
            rdy_tmr <= '0;
          end else if (go_load) begin
            state    <= LOAD;
            dly_ld_o <= '1;
          end else if (accept) begin
            state     <= STEP;
            dly_inc_o <= step_inc_i;
            if (clip) err_o    <= 1'b1;
            else      dly_ce_o <= sel;
          end
        end
        ERROR: begin
          ready_o <= 1'b0;
          if (cfg_load_i) begin
            state   <= WAIT_RDY;
            rdy_tmr <= '0;
            err_o   <= 1'b0;
          end
        end
        default: state <= WAIT_RDY;
      endcase
    end
  end
endmodule

// File: tb/tb_rgmii_idelay_ctrl.sv
// Directed bench for rgmii_idelay_ctrl: load/clamp, timeout/retry, stepping, clips, reset.
module tb_rgmii_idelay_ctrl;
  localparam int LANES = 5, TAP_W = 6, MAX_TAP = 31, SETTLE_CYC = 4, RDY_TIMEOUT = 16;
  localparam int LW = $clog2(LANES);

  localparam logic [LANES*TAP_W-1:0] CFG_A  = {6'd40, 6'd31, 6'd12, 6'd7, 6'd3};
  localparam logic [LANES*TAP_W-1:0] TAPS_A = {6'd31, 6'd31, 6'd12, 6'd7, 6'd3};
  localparam logic [LANES*TAP_W-1:0] CFG_B  = {6'd5,  6'd31, 6'd20, 6'd9, 6'd0};
  localparam logic [LANES*TAP_W-1:0] CFG_C  = {6'd63, 6'd1,  6'd2,  6'd3, 6'd4};
  localparam logic [LANES*TAP_W-1:0] TAPS_C = {6'd31, 6'd1,  6'd2,  6'd3, 6'd4};

  logic                     clk_int = 1'b0;
  logic                     rst_int_n = 1'b0;
  logic                     dlyctrl_rdy_i = 1'b0;
  logic [LANES*TAP_W-1:0]   cfg_tap_i = '0;
  logic                     cfg_load_i = 1'b0;
  logic                     step_valid_i = 1'b0;
  logic [LW-1:0]            step_lane_i = '0;
  logic                     step_inc_i = 1'b0;
  logic                     step_ready_o, dly_inc_o, busy_o, ready_o, err_o;
  logic [LANES-1:0]         dly_ld_o, dly_ce_o;
  logic [LANES*TAP_W-1:0]   dly_cntvaluein_o, tap_o;

  int n_chk = 0, n_fail = 0;

  rgmii_idelay_ctrl #(
    .LANES(LANES), .TAP_W(TAP_W), .MAX_TAP(MAX_TAP),
    .SETTLE_CYC(SETTLE_CYC), .RDY_TIMEOUT(RDY_TIMEOUT)
  ) dut (
    .clk_int(clk_int), .rst_int_n(rst_int_n), .dlyctrl_rdy_i(dlyctrl_rdy_i),
    .cfg_tap_i(cfg_tap_i), .cfg_load_i(cfg_load_i), .step_valid_i(step_valid_i),
    .step_lane_i(step_lane_i), .step_inc_i(step_inc_i), .step_ready_o(step_ready_o),
    .dly_ld_o(dly_ld_o), .dly_ce_o(dly_ce_o), .dly_inc_o(dly_inc_o),
    .dly_cntvaluein_o(dly_cntvaluein_o), .tap_o(tap_o), .busy_o(busy_o),
    .ready_o(ready_o), .err_o(err_o)
  );

  always #5 clk_int = ~clk_int;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_int);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_tap(input int i);
    return 32'(tap_o[i*TAP_W +: TAP_W]);
  endfunction

  task automatic step_req(input int lane, input logic inc);
    step_valid_i = 1'b1;
    step_lane_i  = LW'(lane);
    step_inc_i   = inc;
  endtask

  initial begin
    int stray;
    // reset
    tick();
    chk("rst_ld",    32'(dly_ld_o), 0);
    chk("rst_ce",    32'(dly_ce_o), 0);
    chk("rst_inc",   32'(dly_inc_o), 0);
    chk("rst_tap",   32'(tap_o), 0);
    chk("rst_cntv",  32'(dly_cntvaluein_o), 0);
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_err",   32'(err_o), 0);
    chk("rst_busy",  32'(busy_o), 1);
    chk("rst_sready",32'(step_ready_o), 0);

    // initial load after rdy, with clamp of lane 4
    rst_int_n = 1'b1;
    cfg_tap_i = CFG_A;
    tick(9);
    chk("pre_ld", 32'(dly_ld_o), 0);
    dlyctrl_rdy_i = 1'b1;
    tick();
    chk("load_ld",   32'(dly_ld_o), 32'h1f);
    chk("load_tap",  32'(tap_o), 32'(TAPS_A));
    chk("load_cntv", 32'(dly_cntvaluein_o), 32'(TAPS_A));
    tick();
    chk("load_ld_once", 32'(dly_ld_o), 0);
    tick(3);
    chk("settle_ready0", 32'(ready_o), 0);
    tick();
    chk("idle_ready", 32'(ready_o), 1);
    chk("idle_busy",  32'(busy_o), 0);
    chk("idle_sready",32'(step_ready_o), 1);

    // three back-to-back increments on lane 2 (12 -> 15), CE every 6 cycles
    step_req(2, 1'b1);
    tick();
    chk("inc1_ce", 32'(dly_ce_o), 32'h04);
    chk("inc1_inc",32'(dly_inc_o), 1);
    stray = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 6 || k == 12) chk($sformatf("inc_ce_k%0d", k), 32'(dly_ce_o), 32'h04);
      else if (dly_ce_o != '0) stray++;
    end
    step_valid_i = 1'b0;
    chk("inc_stray_ce", 32'(stray), 0);
    chk("inc_tap2", lane_tap(2), 15);
    chk("inc_err",  32'(err_o), 0);
    tick(5);

    // cfg_load and step in the same cycle: load wins, step waits for settle
    cfg_tap_i  = CFG_B;
    cfg_load_i = 1'b1;
    step_req(1, 1'b1);
    #1;
    chk("prio_sready", 32'(step_ready_o), 0);
    tick();
    cfg_load_i = 1'b0;
    chk("prio_ld",  32'(dly_ld_o), 32'h1f);
    chk("prio_ce",  32'(dly_ce_o), 0);
    chk("prio_tap", 32'(tap_o), 32'(CFG_B));
    stray = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (dly_ce_o != '0) stray++;
    end
    chk("prio_wait_ce", 32'(stray), 0);
    tick();
    step_valid_i = 1'b0;
    chk("prio_step_ce", 32'(dly_ce_o), 32'h02);
    chk("prio_tap1",    lane_tap(1), 10);
    tick(5);

    // clipped steps: lane 0 dec at 0, lane 3 inc at 31, lane 5 out of range
    step_req(0, 1'b0);
    tick();
    step_valid_i = 1'b0;
    chk("clip0_ce",    32'(dly_ce_o), 0);
    chk("clip0_tap",   lane_tap(0), 0);
    chk("clip0_err",   32'(err_o), 1);
    chk("clip0_ready", 32'(ready_o), 1);
    chk("clip0_busy",  32'(busy_o), 1);
    tick(5);
    step_req(3, 1'b1);
    tick();
    step_valid_i = 1'b0;
    chk("clip3_ce",  32'(dly_ce_o), 0);
    chk("clip3_tap", lane_tap(3), 31);
    chk("clip3_err", 32'(err_o), 1);
    tick(5);
    step_req(5, 1'b1);
    tick();
    step_valid_i = 1'b0;
    chk("lane5_ce",  32'(dly_ce_o), 0);
    chk("lane5_tap", 32'(tap_o), 32'({6'd5, 6'd31, 6'd20, 6'd10, 6'd0}));
    chk("lane5_ready", 32'(ready_o), 1);
    tick(5);

    // reset on the CE-pulse cycle
    step_req(2, 1'b0);
    tick();
    step_valid_i = 1'b0;
    chk("rstce_ce", 32'(dly_ce_o), 32'h04);
    chk("rstce_tap2", lane_tap(2), 19);
    rst_int_n     = 1'b0;
    dlyctrl_rdy_i = 1'b0;
    tick();
    chk("rstce_ce0",  32'(dly_ce_o), 0);
    chk("rstce_tap0", 32'(tap_o), 0);
    chk("rstce_busy", 32'(busy_o), 1);
    chk("rstce_err",  32'(err_o), 0);
    chk("rstce_ready",32'(ready_o), 0);

    // ready timeout, then retry
    rst_int_n = 1'b1;
    cfg_tap_i = CFG_A;
    tick(15);
    chk("tmo_err_early", 32'(err_o), 0);
    tick();
    chk("tmo_err",    32'(err_o), 1);
    chk("tmo_sready", 32'(step_ready_o), 0);
    chk("tmo_busy",   32'(busy_o), 1);
    dlyctrl_rdy_i = 1'b1;
    cfg_load_i    = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    chk("retry_err", 32'(err_o), 0);
    tick();
    chk("retry_ld",  32'(dly_ld_o), 32'h1f);
    chk("retry_tap", 32'(tap_o), 32'(TAPS_A));
    tick(5);
    chk("retry_ready", 32'(ready_o), 1);
    chk("retry_err2",  32'(err_o), 0);

    // rdy drops in IDLE: back to WAIT_RDY, reload from current cfg
    dlyctrl_rdy_i = 1'b0;
    cfg_tap_i     = CFG_C;
    tick();
    chk("drop_ready", 32'(ready_o), 0);
    chk("drop_busy",  32'(busy_o), 1);
    dlyctrl_rdy_i = 1'b1;
    tick();
    chk("drop_ld",  32'(dly_ld_o), 32'h1f);
    chk("drop_tap", 32'(tap_o), 32'(TAPS_C));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rgmii_idelay_ctrl.md
Name: rgmii_idelay_ctrl

Overview:
- Parametrised run-time controller for the RGMII receive-path input delays. Replaces fixed-tap delays with VARIABLE/VAR_LOAD taps on N lanes.
- Waits for the delay-reference controller to report ready, then loads per-lane tap values.
- Accepts single-step increment/decrement requests from a training engine or register block.
- Keeps a shadow copy of every tap and drives the C/CE/INC/LD/CNTVALUEIN pins of each delay element. Sits between the uDMA ethernet config registers and the RGMII PHY receive path.

Parameters:
- LANES, 5, delay lanes (4 rxd + rx_ctl)
- TAP_W, 5, tap value width
- MAX_TAP, 31, highest legal tap, at most 2**TAP_W-1
- SETTLE_CYC, 4, idle cycles after any LD/CE pulse before the next operation
- RDY_TIMEOUT, 1024, cycles to wait for the delay-reference ready before flagging an error

Ports:
- clk_int  in  1  controller and delay-element clock (drives the delay C pin)
- rst_int_n  in  1  synchronous active-low reset
- dlyctrl_rdy_i  in  1  delay-reference ready, already synchronised
- cfg_tap_i  in  LANES*TAP_W  tap value per lane, lane 0 in the LSBs
- cfg_load_i  in  1  pulse: load every lane from cfg_tap_i
- step_valid_i  in  1  step request valid
- step_lane_i  in  $clog2(LANES)  lane to step
- step_inc_i  in  1  1 = increment, 0 = decrement
- step_ready_o  out  1  step request accepted when valid && ready
- dly_ld_o  out  LANES  per-lane LD strobe
- dly_ce_o  out  LANES  per-lane CE strobe
- dly_inc_o  out  1  INC level shared by all lanes
- dly_cntvaluein_o  out  LANES*TAP_W  per-lane load values
- tap_o  out  LANES*TAP_W  shadow tap values
- busy_o  out  1  high in any state other than IDLE
- ready_o  out  1  initial load done and no error
- err_o  out  1  sticky: timeout or step clipped at a limit

Behaviour:
- Reset, sampled on the clk_int edge while rst_int_n=0:
  - state=WAIT_RDY.
  - All strobes 0, dly_inc_o=0.
  - tap_o=0 and dly_cntvaluein_o=0.
  - ready_o=0, err_o=0, busy_o=1, step_ready_o=0.
  - A reset in the middle of any operation drops strobes the same cycle and abandons the operation.
- WAIT_RDY:
  - Counts cycles while dlyctrl_rdy_i=0.
  - When dlyctrl_rdy_i=1 -> LOAD, latching cfg_tap_i. Each lane is clamped to MAX_TAP.
  - When the count reaches RDY_TIMEOUT -> ERROR with err_o=1.
- LOAD: one cycle with dly_ld_o all ones and dly_cntvaluein_o set to the clamped values; tap_o updates the same cycle. -> SETTLE.
- SETTLE: SETTLE_CYC cycles with all strobes 0. -> IDLE; ready_o=1 from the first IDLE cycle.
- IDLE:
  - busy_o=0 and step_ready_o=1.
  - cfg_load_i has priority over step_valid_i if both are asserted in the same cycle; the step is not accepted (step_ready_o=0 that cycle).
  - cfg_load_i -> LOAD.
  - Accepted step -> STEP.
- STEP:
  - One cycle with dly_ce_o[lane]=1 and dly_inc_o=step_inc_i (registered at accept).
  - Shadow tap ±1. -> SETTLE.
  - Increment at MAX_TAP or decrement at 0: no CE pulse, tap unchanged, err_o set, still -> SETTLE. The wrap-around of the hardware element is never exercised.
  - step_lane_i >= LANES: treated as clipped (err_o=1, no pulse).
- ERROR:
  - busy_o=1, ready_o=0, step_ready_o=0.
  - cfg_load_i retries: -> WAIT_RDY, timer cleared, err_o cleared.
- err_o is cleared only by reset or by a retry from ERROR; ready_o is unaffected by clip errors.
- dlyctrl_rdy_i falling while in IDLE -> WAIT_RDY, ready_o=0. Taps are reloaded from the current cfg_tap_i.
- Latency:
  - cfg_load_i to LD pulse = 1 cycle.
  - Accept to CE pulse = 1 cycle.
  - Next accept no earlier than SETTLE_CYC+2 cycles after the previous accept.

Decomposition:
- Package rgmii_dly_pkg:
  - state enum (WAIT_RDY, LOAD, SETTLE, IDLE, STEP, ERROR)
  - tap typedef logic [TAP_W-1:0]
  - default constants for LANES and MAX_TAP
- One sub-module, rgmii_idelay_lane:
  - shadow register, clamp and ±1 saturation logic per lane
  - instantiated LANES times by a generate loop
- The FSM and timers stay in the top.

Test Plan:
- rdy rises at cycle 10, cfg_tap_i lanes={3,7,12,31,40→clamped 31} -> one LD pulse at cycle 11; tap_o={3,7,12,31,31}; ready_o=1 at cycle 16.
- rdy held low, RDY_TIMEOUT=16 -> err_o=1 after 16 cycles in WAIT_RDY. Then rdy=1 plus a cfg_load_i pulse -> load completes, err_o=0.
- Lane 2 at tap 12: three increments back-to-back -> CE pulses spaced 6 cycles apart, dly_inc_o=1, tap_o[2]=15.
- Lane 0 at 0, decrement request -> no CE pulse, tap stays 0, err_o=1, ready_o stays 1. Lane 3 at 31, increment -> same behaviour.
- cfg_load_i and step_valid_i in the same IDLE cycle -> LD pulse, step not accepted; the step is accepted after SETTLE.
- rst_int_n low on the CE-pulse cycle -> next edge: strobes 0, tap_o=0, state WAIT_RDY.
